seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one combinational hex-to-7-segment decoder.
- Holds a committed display word and a one-entry pending buffer loaded through a valid/ready handshake.
- Cycles digit enables with a programmable on-time and dead-time.
- Presents one nibble per slot to the shared decoder and gates the returned segment pattern onto the pins.
- Sits between the arithmetic/game logic and the board display pins.

---
 rtl/seg_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Holds a committed display word plus a one-entry pending buffer that is
// swapped in only at a frame boundary, so a frame never shows a mix of two
// words. Presents one nibble per slot to an external shared decoder and
// gates the returned segment pattern onto the pins.
module seg_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    blank_lz,
  output logic [3:0]              nibble_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic                    frame_start
);

  localparam int MAX_COUNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam int IW        = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_DRIVE,
    ST_BLANK
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [NUM_DIGITS-1:0]   display_dp_q, display_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;
  logic                    anode_active;

  // Next-state logic: slot sequencing, frame-boundary commit, load capture
  // and the registered pin values for the cycle that follows.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would make synthesis infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CW'(1);
    display_d    = display_q;
    display_dp_d = display_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_d      = 1'b0;

    case (state_q)
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          if (idx_q == LAST_DIGIT) begin
            // Frame boundary: swap in the pending word so frames never tear.
            idx_d   = '0;
            frame_d = 1'b1;
            if (pend_valid_q) begin
              display_d    = pend_data_q;
              display_dp_d = pend_dp_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase

    // Capture needs an empty buffer while commit needs a full one, so the two
    // writes to pend_valid_d are mutually exclusive.
    if (load_valid && !pend_valid_q) begin
      pend_data_d  = load_data;
      pend_dp_d    = load_dp;
      pend_valid_d = 1'b1;
    end

    // Leading-zero blanking on the word that will be on display next cycle.
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (display_d[4*i +: 4] == 4'd0);
      lz_blank[i] = blank_lz & zero_above;
    end

    anode_d = '1;
    if (state_d == ST_DRIVE && !lz_blank[idx_d]) begin
      anode_d[idx_d] = 1'b0;
    end
    nibble_d = 4'(display_d >> {idx_d, 2'b00});
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= ST_BLANK;
      idx_q        <= LAST_DIGIT;
      cnt_q        <= '0;
      display_q    <= '0;
      display_dp_q <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      nibble_q     <= '0;
      anode_q      <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      display_q    <= display_d;
      display_dp_q <= display_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      nibble_q     <= nibble_d;
      anode_q      <= anode_d;
      frame_q      <= frame_d;
    end
  end

  // Pin gating: segments and decimal point follow the live anode only.
  always_comb begin
    anode_active = ~anode_q[idx_q];
    seg_out      = anode_active ? seg_in : 7'b1111111;
    dp_out       = anode_active ? ~display_dp_q[idx_q] : 1'b1;
  end

  assign load_ready  = ~pend_valid_q;
  assign nibble_out  = nibble_q;
  assign anode_out   = anode_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: a timeline model (position derived from
// cycles since reset) plus a pending-word model, compared every cycle,
// with literal expectations pinning the scan sequence and key events.
module tb_seg_scan_controller;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int D     = 2;
  localparam int SLOT  = R + D;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [4*N-1:0] load_data;
  logic [N-1:0]  load_dp;
  logic          blank_lz;
  logic [3:0]    nibble_out;
  logic [6:0]    seg_in;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [N-1:0]  anode_out;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset, committed/pending words, blank_lz at edge.
  int            m_t;
  logic [4*N-1:0] m_disp, m_pend;
  logic [N-1:0]  m_disp_dp, m_pend_dp;
  bit            m_pv;
  bit            m_bl;

  seg_scan_controller #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .DEAD_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .blank_lz   (blank_lz),
    .nibble_out (nibble_out),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .anode_out  (anode_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Where in the scan timeline cycle t falls.
  task automatic model_pos(input int t, output bit drive, output int idx, output bit fs);
    int u;
    u = t - D;
    if (u < 0) begin
      drive = 1'b0;
      idx   = N - 1;
      fs    = 1'b0;
    end else begin
      idx   = (u / SLOT) % N;
      drive = (u % SLOT) < R;
      fs    = (u % FRAME) == 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit drive, fs, old_pv;
    int idx;
    m_bl = blank_lz;
    if (reset) begin
      m_t = 0; m_disp = '0; m_disp_dp = '0; m_pv = 1'b0;
    end else begin
      old_pv = m_pv;
      m_t++;
      model_pos(m_t, drive, idx, fs);
      if (fs && old_pv) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 1'b0;
      end
      if (load_valid && !old_pv) begin
        m_pend = load_data; m_pend_dp = load_dp; m_pv = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit drive, fs, blanked, active;
    int idx;
    logic [N-1:0] exp_an;
    model_pos(m_t, drive, idx, fs);
    blanked = m_bl && idx > 0 && ((m_disp >> (4 * idx)) == 0);
    active  = drive && !blanked;
    exp_an  = '1;
    if (active) exp_an[idx] = 1'b0;
    check("anode_out",   32'(anode_out),   32'(exp_an));
    check("nibble_out",  32'(nibble_out),  32'((m_disp >> (4 * idx)) & 'hF));
    check("frame_start", 32'(frame_start), 32'(fs));
    check("load_ready",  32'(load_ready),  32'(!m_pv));
    check("seg_out",     32'(seg_out),     32'(active ? seg_in : 7'h7F));
    check("dp_out",      32'(dp_out),      32'(active ? !m_disp_dp[idx] : 1'b1));
  endtask

  task automatic step();
    seg_in = 7'($urandom);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("frame_start_timeout", 0, 1);
  endtask

  initial begin
    logic [3:0] anode_seq [26];
    bit drive, fs;
    int idx;
    bit found;

    anode_seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                  4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0; blank_lz = 1'b0;
    seg_in = '0;
    m_t = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 0; m_bl = 0;

    // Reset state and idle scan sequence.
    repeat (3) step();
    check("reset_anode", 32'(anode_out), 32'(anode_seq[0]));
    check("reset_ready", 32'(load_ready), 1);
    check("reset_seg", 32'(seg_out), 32'h7F);
    check("reset_dp", 32'(dp_out), 1);
    reset = 1'b0;
    for (int k = 1; k < 26; k++) begin
      step();
      check("idle_anode_seq", 32'(anode_out), 32'(anode_seq[k]));
      check("idle_frame_start", 32'(frame_start), 32'(k == 2));
      check("idle_nibble", 32'(nibble_out), 0);
    end

    // Mid-frame load of 1234 with dp on digit 2.
    repeat (3) step();
    load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0100;
    step();
    load_valid = 1'b0;
    step();
    check("load_ready_after_xfer", 32'(load_ready), 0);
    check("display_unchanged", 32'(nibble_out), 0);
    wait_frame();
    check("commit_nibble_d0", 32'(nibble_out), 4);
    step();
    check("ready_after_commit", 32'(load_ready), 1);
    repeat (FRAME) step();

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_valid = 1'b1; load_data = 16'h0050; load_dp = '0;
    step();
    load_valid = 1'b0;
    wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      check("lz_0050_upper_off", 32'(anode_out[3:2]), 32'h3);
      step();
    end
    load_valid = 1'b1; load_data = 16'h0000;
    step();
    load_valid = 1'b0;
    wait_frame();
    for (int k = 0; k < FRAME; k++) begin
      check("lz_0000_upper_off", 32'(anode_out[3:1]), 32'h7);
      step();
    end
    blank_lz = 1'b0;

    // Back-to-back words held on load_valid.
    load_valid = 1'b1; load_data = 16'hAAAA;
    step();
    load_data = 16'hBBBB;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (load_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("aaaa_commit_timeout", 0, 1);
    check("aaaa_shown", 32'(nibble_out), 32'hA);
    step();
    load_valid = 1'b0;
    check("bbbb_pending", 32'(load_ready), 0);
    wait_frame();
    check("bbbb_shown", 32'(nibble_out), 32'hB);

    // Reset during digit 2 DRIVE with a word pending.
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      load_valid = 1'b1; load_data = 16'($urandom); load_dp = 4'($urandom);
      step();
      model_pos(m_t, drive, idx, fs);
      if (drive && idx == 2 && m_pv) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("digit2_pending_timeout", 0, 1);
    load_valid = 1'b0;
    reset = 1'b1;
    step();
    check("midreset_anode", 32'(anode_out), 32'hF);
    check("midreset_ready", 32'(load_ready), 1);
    reset = 1'b0;
    wait_frame();
    check("midreset_display", 32'(nibble_out), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom % 3) == 0;
      load_data  = 16'($urandom);
      if ($urandom % 2) load_data = load_data >> (4 * ($urandom % 4));
      load_dp    = 4'($urandom);
      if ($urandom % 16 == 0) blank_lz = ~blank_lz;
      reset      = ($urandom % 400) == 0;
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
